// File: rtl/atm_ledger_arbiter.sv
// Round-robin ledger arbiter: one atomic check/withdraw/deposit per grant, result acked to the requester.
// Latency: ack 2 cycles after the sampled req, 3 cycles per op back-to-back; no stall path, requests wait at level.
module atm_ledger_arbiter #(
    parameter int               N_TERM   = 2,
    parameter int               BAL_W    = 16,
    parameter logic [BAL_W-1:0] INIT_BAL = 16'd5000,
    parameter logic [BAL_W-1:0] MAX_WD   = 16'd2500,
    localparam int              ID_W     = (N_TERM > 1) ? $clog2(N_TERM) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [N_TERM-1:0]         i_req,
    input  logic [2*N_TERM-1:0]       i_op,
    input  logic [BAL_W*N_TERM-1:0]   i_amount,
    output logic [N_TERM-1:0]         o_ack,
    output logic                      o_ok,
    output logic [BAL_W-1:0]          o_rd_balance,
    output logic [ID_W-1:0]           o_grant_id,
    output logic                      o_busy,
    output logic [BAL_W-1:0]          o_balance
);

    localparam logic [1:0] OP_CHECK = 2'b01;
    localparam logic [1:0] OP_WD    = 2'b10;
    localparam logic [1:0] OP_DEP   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_rr;
    logic [ID_W-1:0]    r_gid;
    logic [1:0]         r_op;
    logic [BAL_W-1:0]   r_amt;
    logic [BAL_W-1:0]   r_bal;
    logic [BAL_W-1:0]   r_rd;
    logic               r_ok;
    logic [N_TERM-1:0]  r_ack;

    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W-1:0]    w_sel;
    logic [BAL_W:0]     w_sum;
    logic               w_ok;
    logic [BAL_W-1:0]   w_nbal;
    logic [N_TERM-1:0]  w_ack_mask;
    logic [ID_W-1:0]    w_rr_next;

    // First requester at or after the round-robin pointer, wrapping at N_TERM.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sel   = '0;
        for (int k = 0; k < N_TERM; k++) begin
            w_sel = ID_W'((int'(r_rr) + k) % N_TERM);
            if (!w_found && i_req[w_sel]) begin
                w_found = 1'b1;
                w_pick  = w_sel;
            end
        end
    end

    always_comb begin
        w_sum  = {1'b0, r_bal} + {1'b0, r_amt};
        w_ok   = 1'b0;
        w_nbal = r_bal;
        case (r_op)
            OP_CHECK: w_ok = 1'b1;
            OP_WD: begin
                if (r_amt != '0 && r_amt <= MAX_WD && r_amt <= r_bal) begin
                    w_ok   = 1'b1;
                    w_nbal = r_bal - r_amt;
                end
            end
            OP_DEP: begin
                if (r_amt != '0 && !w_sum[BAL_W]) begin
                    w_ok   = 1'b1;
                    w_nbal = w_sum[BAL_W-1:0];
                end
            end
            default: w_ok = 1'b0;
        endcase
    end

    assign w_ack_mask = N_TERM'(1) << r_gid;
    assign w_rr_next  = (r_gid == ID_W'(N_TERM - 1)) ? '0 : r_gid + 1'b1;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_found ? S_EXEC : S_IDLE;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rr  <= '0;
            r_gid <= '0;
            r_op  <= '0;
            r_amt <= '0;
            r_bal <= INIT_BAL;
            r_rd  <= '0;
            r_ok  <= 1'b0;
            r_ack <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gid <= w_pick;
                        r_op  <= i_op[2*w_pick +: 2];
                        r_amt <= i_amount[BAL_W*w_pick +: BAL_W];
                    end
                end
                S_EXEC: begin
                    r_bal <= w_nbal;
                    r_rd  <= w_nbal;
                    r_ok  <= w_ok;
                    r_ack <= w_ack_mask;
                    r_rr  <= w_rr_next;
                end
                S_RESP: r_ack <= '0;
                default: r_ack <= '0;
            endcase
        end
    end

    assign o_ack        = r_ack;
    assign o_ok         = r_ok;
    assign o_rd_balance = r_rd;
    assign o_grant_id   = r_gid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_balance    = r_bal;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Bench for atm_ledger_arbiter: directed ledger scenarios then random multi-terminal traffic,
// compared every cycle against a transaction-level ledger model.
module tb_atm_ledger_arbiter;

    localparam int N = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [2*N-1:0] op;
    logic [16*N-1:0] amt;
    logic [N-1:0]  ack;
    logic          ok;
    logic [15:0]   rd;
    logic [0:0]    gid;
    logic          busy;
    logic [15:0]   bal;

    atm_ledger_arbiter dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_req        (req),
        .i_op         (op),
        .i_amount     (amt),
        .o_ack        (ack),
        .o_ok         (ok),
        .o_rd_balance (rd),
        .o_grant_id   (gid),
        .o_busy       (busy),
        .o_balance    (bal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec;
    int nerr;
    bit auto_mode;
    logic [N-1:0] ack_s;
    bit   last_ok [N];
    int   last_rd [N];

    // Ledger model: a grant at edge g completes at edge g+1, the arbiter is free again from edge g+3.
    int cyc, m_g, m_bal, m_nbal, m_rr, m_gid, m_rd;
    bit m_act, m_ok, m_pok;

    function automatic void ledger(input int o, input int a, input int b, output bit okv, output int nb);
        okv = 1'b0;
        nb  = b;
        case (o)
            1: okv = 1'b1;
            2: if (a > 0 && a <= 2500 && a <= b) begin okv = 1'b1; nb = b - a; end
            3: if (a > 0 && b + a <= 65535) begin okv = 1'b1; nb = b + a; end
            default: okv = 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        cyc = 0; m_g = 0; m_act = 0; m_bal = 5000; m_nbal = 5000;
        m_rr = 0; m_gid = 0; m_ok = 0; m_pok = 0; m_rd = 0;
    endtask

    task automatic model_edge();
        cyc++;
        if (m_act) begin
            if (cyc == m_g + 1) begin
                m_bal = m_nbal; m_ok = m_pok; m_rd = m_nbal; m_rr = (m_gid + 1) % N;
            end else if (cyc == m_g + 2) begin
                m_act = 0;
            end
        end else if (req != 0) begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_rr + k) % N]) begin m_gid = (m_rr + k) % N; break; end
            end
            m_g = cyc; m_act = 1;
            ledger(int'(op[2*m_gid +: 2]), int'(amt[16*m_gid +: 16]), m_bal, m_pok, m_nbal);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        int exp_ack;
        bit exp_busy;
        exp_ack  = (m_act && cyc == m_g + 1) ? (1 << m_gid) : 0;
        exp_busy = m_act && (cyc <= m_g + 1);
        chk("ack", 32'(ack), exp_ack);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("balance", 32'(bal), m_bal);
        chk("grant_id", 32'(gid), m_gid);
        if (exp_ack != 0) begin
            chk("ok", 32'(ok), 32'(m_ok));
            chk("rd_balance", 32'(rd), m_rd);
        end
        ack_s = ack;
        for (int t = 0; t < N; t++) begin
            if (ack[t]) begin last_ok[t] = ok; last_rd[t] = int'(rd); end
        end
    endtask

    function automatic logic [15:0] pick_amt();
        case ($urandom_range(5))
            0: return 16'd0;
            1: return 16'd2500;
            2: return 16'd2501;
            3: return 16'(m_bal);
            4: return 16'(65535 - m_bal);
            default: return 16'($urandom_range(3000));
        endcase
    endfunction

    task automatic drive_random();
        for (int t = 0; t < N; t++) begin
            if (ack_s[t]) begin
                req[t] = 1'b0;
            end else if (!req[t] && $urandom_range(3) == 0) begin
                req[t] = 1'b1;
                op[2*t +: 2] = 2'($urandom_range(3));
                amt[16*t +: 16] = pick_amt();
            end else if (req[t] && $urandom_range(7) == 0) begin
                op[2*t +: 2] = 2'($urandom_range(3));
                amt[16*t +: 16] = pick_amt();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (auto_mode) drive_random();
        @(negedge clk);
        compare();
    endtask

    task automatic run_op(input int t, input logic [1:0] o, input logic [15:0] a, input bit scramble,
                          output bit okv, output int rdv, output int lat, output int bcnt);
        req[t] = 1'b1;
        op[2*t +: 2] = o;
        amt[16*t +: 16] = a;
        lat = 0;
        bcnt = 0;
        while (1) begin
            step();
            lat++;
            if (busy) bcnt++;
            if (scramble && lat == 1) begin op[2*t +: 2] = 2'b11; amt[16*t +: 16] = 16'd7; end
            if (ack_s[t]) break;
            if (lat >= 30) begin
                nvec++; nerr++;
                $display("FAIL ack_timeout: terminal %0d got no ack in %0d cycles, required ack within 2", t, lat);
                break;
            end
        end
        req[t] = 1'b0;
        okv = last_ok[t];
        rdv = last_rd[t];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
        $fatal(1);
    end

    initial begin
        bit k;
        int r, l, b, n, c0, c1, acks;
        nvec = 0; nerr = 0; auto_mode = 0;
        rst_n = 1'b0; req = '0; op = '0; amt = '0; ack_s = '0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();

        chk("t1_balance", 32'(bal), 5000);
        chk("t1_ack", 32'(ack), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_grant_id", 32'(gid), 0);
        chk("t1_ok", 32'(ok), 0);
        chk("t1_rd", 32'(rd), 0);

        run_op(0, 2'b10, 16'd1000, 1'b1, k, r, l, b);
        chk("t2_ok", 32'(k), 1);
        chk("t2_rd", r, 4000);
        chk("t2_latency", l, 2);
        chk("t2_busy_cycles", b, 2);
        step();
        chk("t2_balance", 32'(bal), 4000);

        run_op(1, 2'b10, 16'd3000, 1'b0, k, r, l, b);
        chk("t3_wd3000_ok", 32'(k), 0);
        run_op(1, 2'b10, 16'd0, 1'b0, k, r, l, b);
        chk("t3_wd0_ok", 32'(k), 0);
        chk("t3_balance", 32'(bal), 4000);

        step();
        req = 2'b11; op = {2'b11, 2'b01}; amt = {16'd500, 16'd0};
        n = 0; c0 = 0; c1 = 0;
        while ((c0 == 0 || c1 == 0) && n < 40) begin
            step();
            n++;
            if (ack_s[0] && c0 == 0) begin c0 = n; req[0] = 1'b0; end
            if (ack_s[1] && c1 == 0) begin c1 = n; req[1] = 1'b0; end
        end
        chk("t4_t0_ack_cycle", c0, 2);
        chk("t4_t1_ack_cycle", c1, 5);
        chk("t4_t0_rd", last_rd[0], 4000);
        chk("t4_t1_ok", 32'(last_ok[1]), 1);
        chk("t4_t1_rd", last_rd[1], 4500);

        run_op(0, 2'b11, 16'hFFFF, 1'b0, k, r, l, b);
        chk("t5_depFFFF_ok", 32'(k), 0);
        chk("t5_depFFFF_rd", r, 4500);
        run_op(1, 2'b10, 16'd2500, 1'b0, k, r, l, b);
        chk("t5_wd2500_rd", r, 2000);
        run_op(0, 2'b10, 16'd2500, 1'b0, k, r, l, b);
        chk("t5_wd2500_short_ok", 32'(k), 0);
        run_op(1, 2'b10, 16'd2000, 1'b0, k, r, l, b);
        chk("t5_wd_all_ok", 32'(k), 1);
        chk("t5_wd_all_rd", r, 0);
        run_op(0, 2'b11, 16'hFFFF, 1'b0, k, r, l, b);
        chk("t5_dep_to_max_rd", r, 65535);
        run_op(1, 2'b11, 16'd1, 1'b0, k, r, l, b);
        chk("t5_dep_carry_ok", 32'(k), 0);

        step();
        req[0] = 1'b1; op[1:0] = 2'b10; amt[15:0] = 16'd100;
        step();
        chk("t6_busy_in_exec", 32'(busy), 1);
        rst_n = 1'b0;
        model_reset();
        req = '0;
        #1;
        chk("t6_rst_balance", 32'(bal), 5000);
        chk("t6_rst_ack", 32'(ack), 0);
        chk("t6_rst_grant_id", 32'(gid), 0);
        step();
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin step(); acks |= int'(ack_s); end
        chk("t6_no_ack", acks, 0);
        chk("t6_balance", 32'(bal), 5000);

        auto_mode = 1;
        repeat (3000) step();
        auto_mode = 0;
        n = 0;
        while (req != 0 && n < 100) begin
            step();
            for (int t = 0; t < N; t++) if (ack_s[t]) req[t] = 1'b0;
            n++;
        end
        chk("drain_pending_req", 32'(req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
